// File: rtl/fpga_cfg_loader_pkg.sv
// Shared register map, bit positions and FSM encodings
// for the fabric configuration loader.
package fpga_cfg_loader_pkg;

  localparam logic [3:0] OFF_CTRL = 4'h0;
  localparam logic [3:0] OFF_LEN  = 4'h4;
  localparam logic [3:0] OFF_DATA = 4'h8;
  localparam logic [3:0] OFF_STAT = 4'hC;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_FRST  = 2;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_EMPTY = 3;
  localparam int ST_OVF   = 4;
  localparam int ST_LERR  = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/cfg_word_fifo.sv
// Small synchronous word FIFO feeding the config serialiser.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module cfg_word_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] din,
  output logic [31:0] head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Wishbone-controlled loader that streams bitstream words
// LSB-first into the fabric config chain, then latches and releases it.
module fpga_cfg_loader
  import fpga_cfg_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
  parameter int          FIFO_DEPTH = 4,
  parameter int          LEN_W      = 20
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cfg_shift_en_o,
  output logic        cfg_bit_o,
  output logic        cfg_load_o,
  output logic        fabric_rst_o,
  output logic        cfg_done_o
);

  logic [1:0]       state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [4:0]       idx_q;
  logic             force_q;
  logic             ovf_q;
  logic             lerr_q;
  logic             ack_q;
  logic [31:0]      dat_q;
  logic             shift_q;
  logic             bit_q;
  logic             load_q;
  logic             done_q;
  logic             frst_q;

  logic        hit, acc, wr, rd;
  logic [3:0]  off;
  logic        wr_ctrl, start_w, abort_w, push;
  logic        idle_like, go, lerr_set;
  logic        do_shift, last, pop, done_nxt;
  logic [31:0] head;
  logic        full, empty;
  logic [31:0] rdata;

  assign off  = wbs_adr_i[3:0];
  assign hit  = wbs_cyc_i & wbs_stb_i &
                (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc  = hit & ~ack_q;
  assign wr   = acc & wbs_we_i & (wbs_sel_i == 4'hF);
  assign rd   = acc & ~wbs_we_i;

  assign wr_ctrl = wr & (off == OFF_CTRL);
  assign abort_w = wr_ctrl & wbs_dat_i[CTRL_ABORT];
  assign start_w = wr_ctrl & wbs_dat_i[CTRL_START] &
                   ~wbs_dat_i[CTRL_ABORT];
  assign push    = wr & (off == OFF_DATA);

  assign idle_like = (state_q == S_IDLE) | (state_q == S_DONE);
  assign go        = start_w & idle_like & (len_q != '0);
  assign lerr_set  = start_w & idle_like & (len_q == '0);

  assign do_shift = (state_q == S_SHIFT) & ~empty & ~abort_w;
  assign last     = ((cnt_q + LEN_W'(1)) == len_q);
  // The word is retired on its final bit or on the last
  // bit of the stream, which drops any unused tail bits.
  assign pop      = do_shift & ((idx_q == 5'd31) | last);
  assign done_nxt = (state_q == S_DONE) & ~abort_w & ~start_w;

  cfg_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .pop   (pop),
    .flush (abort_w),
    .din   (wbs_dat_i),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL: rdata[CTRL_FRST] = force_q;
      OFF_LEN:  rdata[LEN_W-1:0] = len_q;
      OFF_STAT: begin
        rdata[ST_BUSY]  = (state_q == S_SHIFT) |
                          (state_q == S_LOAD);
        rdata[ST_DONE]  = done_q;
        rdata[ST_FULL]  = full;
        rdata[ST_EMPTY] = empty;
        rdata[ST_OVF]   = ovf_q;
        rdata[ST_LERR]  = lerr_q;
        rdata[31:8]     = 24'(cnt_q);
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      force_q <= 1'b0;
      ovf_q   <= 1'b0;
      lerr_q  <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      shift_q <= 1'b0;
      bit_q   <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      frst_q  <= 1'b1;
    end else begin
      ack_q   <= acc;
      dat_q   <= rd ? rdata : '0;
      shift_q <= do_shift;
      bit_q   <= do_shift ? head[idx_q] : 1'b0;
      load_q  <= (state_q == S_LOAD) & ~abort_w;
      // Fabric reset is released only after the load strobe.
      done_q  <= done_nxt;
      frst_q  <= ~done_nxt | force_q;

      if (wr_ctrl) force_q <= wbs_dat_i[CTRL_FRST];
      if (wr && off == OFF_LEN && idle_like)
        len_q <= wbs_dat_i[LEN_W-1:0];

      if (start_w) begin
        ovf_q  <= 1'b0;
        lerr_q <= 1'b0;
      end
      if (push && full && !pop) ovf_q <= 1'b1;
      if (lerr_set) lerr_q <= 1'b1;

      if (abort_w) begin
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE: begin
            if (go) begin
              state_q <= S_SHIFT;
              cnt_q   <= '0;
              idx_q   <= '0;
            end else if (lerr_set) begin
              state_q <= S_IDLE;
            end
          end
          S_SHIFT: begin
            if (do_shift) begin
              cnt_q <= cnt_q + LEN_W'(1);
              idx_q <= pop ? 5'd0 : idx_q + 5'd1;
              if (last) state_q <= S_LOAD;
            end
          end
          S_LOAD:  state_q <= S_DONE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign wbs_ack_o      = ack_q;
  assign wbs_dat_o      = dat_q;
  assign cfg_shift_en_o = shift_q;
  assign cfg_bit_o      = bit_q;
  assign cfg_load_o     = load_q;
  assign cfg_done_o     = done_q;
  assign fabric_rst_o   = frst_q;

endmodule
